// File: rtl/sixteen_subtractor_serial_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM states and size defaults.
package sixteen_subtractor_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGIT_DEF  = 4;
  localparam int NUM_DIGITS = WIDTH_DEF / DIGIT_DEF;

endpackage

// File: rtl/sixteen_subtractor_serial_digit_subtractor.sv
// One DIGIT-bit slice of the subtractor: {bo, diff} = x - y - bi.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] diff,
  output logic             bo
);

  logic [DIGIT:0] full;

  // Subtract in DIGIT+1 bits; the top bit is set exactly when the slice underflows.
  always_comb begin
    full = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
    diff = full[DIGIT-1:0];
    bo   = full[DIGIT];
  end

endmodule

// File: rtl/sixteen_subtractor_serial.sv
// Digit-serial unsigned subtractor: d = a - b - bin, one DIGIT slice per cycle, LSB first.
//
// Handshake: a transfer on either side happens on a rising edge where valid and
// ready are both 1. in_ready is 1 only in IDLE; operands are sampled only on the
// accepting edge. out_valid, once 1, stays 1 with d/bout stable until out_ready=1.
module sixteen_subtractor_serial
  import sixteen_subtractor_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready,
  output state_e           dbg_state
);

  localparam int NUM = WIDTH / DIGIT;
  localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ov_q, ov_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      lsb;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] slice_diff;
  logic             slice_bo;

  // Select the current slice of both operands by shifting it down to bit 0.
  always_comb begin
    lsb  = 32'(cnt_q) * DIGIT;
    a_sh = a_q >> lsb;
    b_sh = b_q >> lsb;
  end

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .bi   (borrow_q),
    .diff (slice_diff),
    .bo   (slice_bo)
  );

  // FSM next state, datapath updates and handshake outputs.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ov_d     = ov_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          res_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // res is cleared on acceptance, so OR-ing each slice into place is enough.
        res_d    = res_q | (WIDTH'(slice_diff) << lsb);
        borrow_d = slice_bo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        // Result is registered onto d/bout one edge after entering DONE, then held.
        if (ov_q) begin
          if (out_ready) begin
            ov_d    = 1'b0;
            d_d     = '0;
            bout_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          ov_d   = 1'b1;
          d_d    = res_q;
          bout_d = borrow_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ov_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ov_q     <= ov_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign d         = d_q;
  assign bout      = bout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sixteen_subtractor_serial.sv
// Bench for sixteen_subtractor_serial: directed vectors, backpressure, reset abort,
// and a random back-to-back run checked against an arithmetic reference queue.
module tb_sixteen_subtractor_serial;
  import sixteen_subtractor_serial_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic [15:0] d;
  logic        bout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  state_e      dbg_state;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int ready_mode = 1;      // 0: hold low, 1: hold high, 2: random
  logic prev_ov = 1'b0;

  logic [16:0] exp_q[$];   // expected {bout, d} per accepted operation
  int          acc_q[$];   // edge index of each acceptance

  sixteen_subtractor_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .d         (d),
    .bout      (bout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Clock and edge counter; record acceptance edges for the latency check.
  always #5 clk = ~clk;
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst_n && in_valid && in_ready) acc_q.push_back(edge_n);
  end

  // out_ready driver, changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mbin);
    return {1'b0, ma} - {1'b0, mb} - {16'b0, mbin};
  endfunction

  // Scoreboard: every cycle out of reset, check outputs against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("result", 32'({bout, d}), 32'(exp_q[0]));
          if (!prev_ov) begin
            if (acc_q.size() != 0) chk("latency", 32'(edge_n - acc_q.pop_front()), 32'd5);
            else chk("latency_no_accept", 32'd1, 32'd0);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_outputs_zero", 32'({bout, d}), 32'd0);
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // Present one operation once in_ready is seen; callers are just after a rising edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd1, 32'd0);
      return;
    end
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    exp_q.push_back(model(ta, tb_v, tbin));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom_range(0, 1));
  endtask

  // Wait for out_valid and compare against a hand-computed literal.
  task automatic wait_result(input string name, input logic [15:0] ed, input logic eb);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_d"}, 32'(d), 32'(ed));
    chk({name, "_bout"}, 32'(bout), 32'(eb));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    exp_q.delete(); acc_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] hold_d;
    logic        hold_b;
    int n;

    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);

    // Directed vectors with hand-computed results.
    ready_mode = 1;
    send(16'h1234, 16'h0234, 1'b0); wait_result("v_1234", 16'h1000, 1'b0);
    send(16'h0000, 16'h0001, 1'b0); wait_result("v_wrap", 16'hFFFF, 1'b1);
    send(16'h8000, 16'h7FFF, 1'b1); wait_result("v_ripple", 16'h0000, 1'b0);
    send(16'h0000, 16'h0000, 1'b1); wait_result("v_bin_only", 16'hFFFF, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b0); wait_result("v_equal", 16'h0000, 1'b0);
    send(16'hA5C3, 16'h1F2E, 1'b1); wait_result("v_mixed", 16'h8694, 1'b0);

    // Backpressure: hold DONE, try to inject a second op, then release.
    ready_mode = 0;
    @(posedge clk); #1;
    send(16'h4321, 16'h1111, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_valid", 32'(out_valid), 32'd1);
    hold_d = d; hold_b = bout;
    chk("bp_d", 32'(hold_d), 32'h3210);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; bin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 32'({bout, d}), 32'({hold_b, hold_d}));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    ready_mode = 1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset during the second CALC cycle aborts the operation.
    send(16'h5555, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete(); acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_outputs", 32'({out_valid, bout, d}), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_valid", 32'(out_valid), 32'd0);

    // Random back-to-back operations with random out_ready.
    ready_mode = 2;
    for (int i = 0; i < 1000; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
